// File: rtl/dsp_mac_sequencer.sv
// Operand sequencer for a DSP48A1 slice: issues (A,B) beats with a per-beat OPMODE that
// accumulates dot products, and buffers each vector's result, length and sticky carry.
module dsp_mac_sequencer #(
   parameter int LATENCY = 3,
   parameter int CNT_W   = 16
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic             S_VALID,
   output logic             S_READY,
   input  logic [17:0]      S_A,
   input  logic [17:0]      S_B,
   input  logic             S_LAST,
   output logic [17:0]      DSP_A,
   output logic [17:0]      DSP_B,
   output logic [17:0]      DSP_D,
   output logic [47:0]      DSP_C,
   output logic [7:0]       DSP_OPMODE,
   output logic             DSP_CARRYIN,
   output logic             DSP_CE,
   output logic             DSP_RST,
   input  logic [47:0]      DSP_P,
   input  logic             DSP_CARRYOUT,
   output logic             M_VALID,
   input  logic             M_READY,
   output logic [47:0]      M_RESULT,
   output logic [CNT_W-1:0] M_COUNT,
   output logic             M_OVF
);

   localparam int               RST_W    = $clog2(LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [7:0]       OP_FIRST = 8'h01;
   localparam logic [7:0]       OP_ACC   = 8'h09;
   localparam logic [7:0]       OP_HOLD  = 8'h08;

   typedef struct packed {
      logic vld;
      logic first;
      logic last;
   } token_t;

   typedef struct packed {
      logic [47:0]      p;
      logic [CNT_W-1:0] cnt;
      logic             ovf;
   } result_t;

   logic [RST_W-1:0] rst_cnt;
   logic             dsp_rst;
   logic             first_pending;
   logic             accept;
   token_t           issue_tok;
   token_t           pipe [LATENCY];
   logic [3:0]       lasts_in_flight;
   logic [4:0]       occupancy;

   logic [CNT_W-1:0] cnt_acc;
   logic [CNT_W-1:0] cnt_cur;
   logic             ovf_acc;
   logic             ovf_cur;
   logic             push;
   logic             pop;

   result_t          buf_mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       buf_count;

   // Slice reset is held for LATENCY cycles after release so every slice stage is flushed.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         rst_cnt <= RST_W'(LATENCY);
      end else if (rst_cnt != '0) begin
         rst_cnt <= rst_cnt - 1'b1;
      end
   end

   assign dsp_rst = (rst_cnt != '0);
   assign DSP_RST = dsp_rst;
   assign DSP_CE  = RSTN;

   assign DSP_D       = '0;
   assign DSP_C       = '0;
   assign DSP_CARRYIN = 1'b0;

   // Every last token still in the pipe reserves a buffer slot ahead of time.
   always_comb begin
      lasts_in_flight = '0;
      for (int i = 0; i < LATENCY; i++) begin
         lasts_in_flight = lasts_in_flight + 4'(pipe[i].vld & pipe[i].last);
      end
   end

   assign occupancy = 5'(buf_count) + 5'(lasts_in_flight);
   assign S_READY   = !dsp_rst && (occupancy < 5'd2);
   assign accept    = S_VALID && S_READY;

   assign DSP_A = accept ? S_A : '0;
   assign DSP_B = accept ? S_B : '0;

   always_comb begin
      issue_tok       = '0;
      issue_tok.vld   = accept;
      issue_tok.first = accept & first_pending;
      issue_tok.last  = accept & S_LAST;
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         for (int i = 0; i < LATENCY; i++) begin
            pipe[i] <= '0;
         end
      end else begin
         pipe[0] <= issue_tok;
         for (int i = 1; i < LATENCY; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   // OPMODE follows the token that the P register is about to absorb.
   always_comb begin
      DSP_OPMODE = OP_HOLD;
      if (dsp_rst) begin
         DSP_OPMODE = '0;
      end else if (pipe[LATENCY-2].vld) begin
         DSP_OPMODE = pipe[LATENCY-2].first ? OP_FIRST : OP_ACC;
      end
   end

   // The last stage lines up with DSP_P/DSP_CARRYOUT for the same token.
   always_comb begin
      cnt_cur = cnt_acc;
      ovf_cur = ovf_acc;
      if (pipe[LATENCY-1].vld) begin
         if (pipe[LATENCY-1].first) begin
            cnt_cur = CNT_W'(1);
            ovf_cur = 1'b0;
         end else begin
            cnt_cur = (cnt_acc == CNT_MAX) ? cnt_acc : cnt_acc + 1'b1;
            ovf_cur = ovf_acc | DSP_CARRYOUT;
         end
      end
   end

   assign push = pipe[LATENCY-1].vld & pipe[LATENCY-1].last;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         first_pending <= 1'b1;
         cnt_acc       <= '0;
         ovf_acc       <= 1'b0;
      end else begin
         if (accept) begin
            first_pending <= S_LAST;
         end
         cnt_acc <= cnt_cur;
         ovf_acc <= ovf_cur;
      end
   end

   assign M_VALID = (buf_count != 2'd0);
   assign pop     = M_VALID && M_READY;

   // At full, a simultaneous push overwrites the head slot exactly as it is popped.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         for (int i = 0; i < 2; i++) begin
            buf_mem[i] <= '0;
         end
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         buf_count <= 2'd0;
      end else begin
         if (push) begin
            buf_mem[wr_ptr].p   <= DSP_P;
            buf_mem[wr_ptr].cnt <= cnt_cur;
            buf_mem[wr_ptr].ovf <= ovf_cur;
            wr_ptr              <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         buf_count <= buf_count + 2'(push) - 2'(pop);
      end
   end

   assign M_RESULT = buf_mem[rd_ptr].p;
   assign M_COUNT  = buf_mem[rd_ptr].cnt;
   assign M_OVF    = buf_mem[rd_ptr].ovf;

   buffer_no_overflow: assert property (@(posedge CLK) disable iff (!RSTN)
      !(push && !pop && buf_count == 2'd2));

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer driving a behavioural DSP48A1 slice model.
module tb_dsp_mac_sequencer;

   localparam int LAT = 3;
   localparam int CW  = 3;

   logic          CLK = 1'b0;
   logic          RSTN = 1'b0;
   logic          S_VALID = 1'b0;
   logic          S_READY;
   logic [17:0]   S_A = '0;
   logic [17:0]   S_B = '0;
   logic          S_LAST = 1'b0;
   logic [17:0]   DSP_A;
   logic [17:0]   DSP_B;
   logic [17:0]   DSP_D;
   logic [47:0]   DSP_C;
   logic [7:0]    DSP_OPMODE;
   logic          DSP_CARRYIN;
   logic          DSP_CE;
   logic          DSP_RST;
   logic [47:0]   DSP_P;
   logic          DSP_CARRYOUT;
   logic          M_VALID;
   logic          M_READY = 1'b0;
   logic [47:0]   M_RESULT;
   logic [CW-1:0] M_COUNT;
   logic          M_OVF;

   int checks   = 0;
   int failures = 0;

   dsp_mac_sequencer #(.LATENCY(LAT), .CNT_W(CW)) dut (
      .CLK          (CLK),
      .RSTN         (RSTN),
      .S_VALID      (S_VALID),
      .S_READY      (S_READY),
      .S_A          (S_A),
      .S_B          (S_B),
      .S_LAST       (S_LAST),
      .DSP_A        (DSP_A),
      .DSP_B        (DSP_B),
      .DSP_D        (DSP_D),
      .DSP_C        (DSP_C),
      .DSP_OPMODE   (DSP_OPMODE),
      .DSP_CARRYIN  (DSP_CARRYIN),
      .DSP_CE       (DSP_CE),
      .DSP_RST      (DSP_RST),
      .DSP_P        (DSP_P),
      .DSP_CARRYOUT (DSP_CARRYOUT),
      .M_VALID      (M_VALID),
      .M_READY      (M_READY),
      .M_RESULT     (M_RESULT),
      .M_COUNT      (M_COUNT),
      .M_OVF        (M_OVF)
   );

   always #5 CLK = ~CLK;

   // Slice model: A1/B1 regs, M reg (signed product, sign-extended), P reg with X/Z muxes.
   logic [17:0]        a1 = '0;
   logic [17:0]        b1 = '0;
   logic [47:0]        m_r = '0;
   logic [47:0]        p_r = '0;
   logic               co_r = 1'b0;
   logic signed [35:0] prod;
   logic [47:0]        x_mux;
   logic [47:0]        z_mux;

   always_comb begin
      prod  = $signed(a1) * $signed(b1);
      x_mux = (DSP_OPMODE[1:0] == 2'b01) ? m_r : 48'd0;
      z_mux = (DSP_OPMODE[3:2] == 2'b10) ? p_r : 48'd0;
   end

   always @(posedge CLK) begin
      if (DSP_RST) begin
         a1   <= '0;
         b1   <= '0;
         m_r  <= '0;
         p_r  <= '0;
         co_r <= 1'b0;
      end else if (DSP_CE) begin
         a1          <= DSP_A;
         b1          <= DSP_B;
         m_r         <= {{12{prod[35]}}, prod};
         {co_r, p_r} <= {1'b0, z_mux} + {1'b0, x_mux};
      end
   end

   assign DSP_P        = p_r;
   assign DSP_CARRYOUT = co_r;

   logic       log_en = 1'b0;
   logic [7:0] op_log[$];

   always @(negedge CLK) begin
      if (log_en) op_log.push_back(DSP_OPMODE);
   end

   initial begin
      #50000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the beat is accepted.
   task automatic send_beat(input logic [17:0] a, input logic [17:0] b, input logic last);
      int waited;
      S_VALID = 1'b1;
      S_A     = a;
      S_B     = b;
      S_LAST  = last;
      waited  = 0;
      while (!S_READY && waited < 50) begin
         @(negedge CLK);
         waited++;
      end
      check("send_ready_wait", 48'(waited < 50), 48'd1);
      @(posedge CLK);
      @(negedge CLK);
      S_VALID = 1'b0;
      S_A     = '0;
      S_B     = '0;
      S_LAST  = 1'b0;
   endtask

   task automatic expect_result(input string tag, input logic [47:0] res,
                                input logic [CW-1:0] cnt, input logic ovf, output int lat);
      lat = 0;
      while (!M_VALID && lat < 40) begin
         @(negedge CLK);
         lat++;
      end
      check({tag, "_valid"},  48'(M_VALID),  48'd1);
      check({tag, "_result"}, M_RESULT,      res);
      check({tag, "_count"},  48'(M_COUNT),  48'(cnt));
      check({tag, "_ovf"},    48'(M_OVF),    48'(ovf));
      M_READY = 1'b1;
      @(negedge CLK);
      M_READY = 1'b0;
   endtask

   int         lat;
   int         n_rst;
   int         n_rdy;
   int         idx;
   int         seen;
   logic [7:0] op;
   logic [7:0] exp_ops [4];

   initial begin
      // Reset state
      repeat (2) @(negedge CLK);
      check("rst_dsp_rst", 48'(DSP_RST),  48'd1);
      check("rst_s_ready", 48'(S_READY),  48'd0);
      check("rst_m_valid", 48'(M_VALID),  48'd0);
      check("rst_dsp_ce",  48'(DSP_CE),   48'd0);
      check("rst_opmode",  48'(DSP_OPMODE), 48'd0);
      check("rst_m_result", M_RESULT,     48'd0);

      RSTN  = 1'b1;
      n_rst = 0;
      n_rdy = 0;
      for (int i = 0; i < 6; i++) begin
         if (DSP_RST) n_rst++;
         if (DSP_RST && S_READY) n_rdy++;
         @(negedge CLK);
      end
      check("rst_hold_cycles", 48'(n_rst), 48'd3);
      check("rst_ready_during", 48'(n_rdy), 48'd0);
      check("post_rst_ready", 48'(S_READY), 48'd1);
      check("post_rst_ce", 48'(DSP_CE), 48'd1);
      check("idle_opmode", 48'(DSP_OPMODE), 48'h08);
      check("idle_m_valid", 48'(M_VALID), 48'd0);

      // Back-to-back vector: 3*4 + 5*6 + 7*8 = 98
      send_beat(18'd3, 18'd4, 1'b0);
      send_beat(18'd5, 18'd6, 1'b0);
      send_beat(18'd7, 18'd8, 1'b1);
      expect_result("t2", 48'd98, 3'd3, 1'b0, lat);
      check("t2_latency", 48'(lat), 48'd3);

      // Same vector with two bubbles after the first beat
      repeat (4) @(negedge CLK);
      log_en = 1'b1;
      send_beat(18'd3, 18'd4, 1'b0);
      repeat (2) @(negedge CLK);
      send_beat(18'd5, 18'd6, 1'b0);
      send_beat(18'd7, 18'd8, 1'b1);
      expect_result("t3", 48'd98, 3'd3, 1'b0, lat);
      log_en = 1'b0;
      idx = -1;
      for (int i = 0; i < op_log.size(); i++) begin
         if (idx < 0 && op_log[i] == 8'h01) idx = i;
      end
      check("t3_first_op", 48'(idx >= 0), 48'd1);
      exp_ops[0] = 8'h08;
      exp_ops[1] = 8'h08;
      exp_ops[2] = 8'h09;
      exp_ops[3] = 8'h09;
      for (int k = 0; k < 4; k++) begin
         op = (idx >= 0 && idx + 1 + k < op_log.size()) ? op_log[idx + 1 + k] : 8'hxx;
         check($sformatf("t3_op%0d", k), 48'(op), 48'(exp_ops[k]));
      end

      // Four 1-beat vectors with the consumer stalled
      send_beat(18'd1, 18'd1, 1'b1);
      send_beat(18'd2, 18'd2, 1'b1);
      check("t4_ready_drop", 48'(S_READY), 48'd0);
      repeat (6) @(negedge CLK);
      check("t4_ready_full", 48'(S_READY), 48'd0);
      check("t4_valid_held", 48'(M_VALID), 48'd1);
      expect_result("t4_r1", 48'd1, 3'd1, 1'b0, lat);
      check("t4_ready_after_pop", 48'(S_READY), 48'd1);
      send_beat(18'd3, 18'd3, 1'b1);
      expect_result("t4_r2", 48'd4, 3'd1, 1'b0, lat);
      send_beat(18'd4, 18'd4, 1'b1);
      expect_result("t4_r3", 48'd9, 3'd1, 1'b0, lat);
      expect_result("t4_r4", 48'd16, 3'd1, 1'b0, lat);

      // Unsigned carry: -16 -> P=FFFF_FFFF_FFF0, then +20 wraps to 4 with carry
      send_beat(18'd16, 18'h3FFFF, 1'b0);
      send_beat(18'd4, 18'd5, 1'b1);
      expect_result("t5", 48'd4, 3'd2, 1'b1, lat);
      send_beat(18'd2, 18'd3, 1'b0);
      send_beat(18'd1, 18'd1, 1'b1);
      expect_result("t5b", 48'd7, 3'd2, 1'b0, lat);

      // Reset pulse mid-vector discards the partial sum
      send_beat(18'd1, 18'd2, 1'b0);
      send_beat(18'd3, 18'd4, 1'b0);
      RSTN = 1'b0;
      @(negedge CLK);
      check("t6_rst_m_valid", 48'(M_VALID), 48'd0);
      check("t6_rst_dsp_rst", 48'(DSP_RST), 48'd1);
      check("t6_rst_opmode", 48'(DSP_OPMODE), 48'd0);
      RSTN = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (M_VALID) seen++;
         @(negedge CLK);
      end
      check("t6_no_result", 48'(seen), 48'd0);
      send_beat(18'd2, 18'd3, 1'b1);
      expect_result("t6", 48'd6, 3'd1, 1'b0, lat);

      // Nine-beat vector saturates the 3-bit counter at 7
      for (int i = 0; i < 9; i++) begin
         send_beat(18'd1, 18'd1, (i == 8));
      end
      expect_result("t7", 48'd9, 3'd7, 1'b0, lat);

      repeat (3) @(negedge CLK);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
